// File: rtl/wb_arbiter2.sv
// wb_arbiter2 -- two-master, one-slave Wishbone classic arbiter.
//
// Shares one slave port between master 0 (instruction fetch) and master 1
// (load/store). Ties are broken round-robin. The owner keeps the bus for its
// whole CYC. A watchdog aborts a transaction that waits too long for ACK and
// signals ERR to the owner.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   i_mN_cyc/stb/we/addr/data       master N request (N = 0, 1)
//   o_mN_ack, o_mN_err              master N completion / watchdog abort
//   o_m_data                        slave read data, broadcast to both masters
//   o_s_cyc/stb/we/addr/data        request to the slave
//   i_s_data, i_s_ack               slave response
//   o_grant                         one-hot owner (01 = m0, 10 = m1, 00 = none)
module wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_m0_cyc,
    input  logic          i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_data,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    input  logic          i_m1_cyc,
    input  logic          i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_data,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m_data,
    output logic          o_s_cyc,
    output logic          o_s_stb,
    output logic          o_s_we,
    output logic [AW-1:0] o_s_addr,
    output logic [DW-1:0] o_s_data,
    input  logic [DW-1:0] i_s_data,
    input  logic          i_s_ack,
    output logic [1:0]    o_grant
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OWN0   = 3'd1,
        OWN1   = 3'd2,
        ABORT0 = 3'd3,
        ABORT1 = 3'd4
    } state_t;

    // The counter holds the number of ack-less cycles already waited. A cycle
    // that starts at TIMEOUT-1 and still sees no ack is the TIMEOUT-th wait,
    // so the abort takes effect on the following cycle. An ack in that same
    // cycle clears the counter and wins the race.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic        last_owner, last_nx;   // 0 = m0 served last, 1 = m1
    logic [15:0] cnt, cnt_nx;
    logic [1:0]  grant_nx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;         // m0 wins the first tie
            cnt        <= '0;
            o_grant    <= 2'b00;
        end else begin
            state      <= state_nx;
            last_owner <= last_nx;
            cnt        <= cnt_nx;
            o_grant    <= grant_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        last_nx  = last_owner;
        cnt_nx   = '0;                  // outside OWNn the counter sits at 0
        case (state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc)
                    state_nx = last_owner ? OWN0 : OWN1;
                else if (i_m0_cyc)
                    state_nx = OWN0;
                else if (i_m1_cyc)
                    state_nx = OWN1;
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                end else if (i_s_ack) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ABORT0;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    state_nx = IDLE;
                    last_nx  = 1'b1;
                end else if (i_s_ack) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = ABORT1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            ABORT0: begin
                if (!i_m0_cyc) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                end
            end
            ABORT1: begin
                if (!i_m1_cyc) begin
                    state_nx = IDLE;
                    last_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // The owner stays granted through its abort until it drops CYC.
        case (state_nx)
            OWN0, ABORT0: grant_nx = 2'b01;
            OWN1, ABORT1: grant_nx = 2'b10;
            default:      grant_nx = 2'b00;
        endcase
    end

    // Output logic: bus mux and ack/err routing, all combinational from state
    // so an asynchronous reset drops slave CYC immediately.
    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = '0;
        o_s_data = '0;
        o_m0_ack = 1'b0;
        o_m0_err = 1'b0;
        o_m1_ack = 1'b0;
        o_m1_err = 1'b0;
        o_m_data = i_s_data;
        case (state)
            OWN0: begin
                o_s_cyc  = i_m0_cyc;
                o_s_stb  = i_m0_stb;
                o_s_we   = i_m0_we;
                o_s_addr = i_m0_addr;
                o_s_data = i_m0_data;
                o_m0_ack = i_s_ack;
            end
            OWN1: begin
                o_s_cyc  = i_m1_cyc;
                o_s_stb  = i_m1_stb;
                o_s_we   = i_m1_we;
                o_s_addr = i_m1_addr;
                o_s_data = i_m1_data;
                o_m1_ack = i_s_ack;
            end
            // Late acks from the slave are swallowed here.
            ABORT0:  o_m0_err = i_m0_cyc;
            ABORT1:  o_m1_err = i_m1_cyc;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (TIMEOUT = 8). Inputs change 2 ns after
// each rising edge and outputs are sampled 1 ns later.
module tb_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_data = '0;
    logic          m0_ack, m0_err;
    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_data = '0;
    logic          m1_ack, m1_err;
    logic [DW-1:0] m_data;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic [DW-1:0] s_rdata = '0;
    logic          s_ack = 0;
    logic [1:0]    grant;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we),
        .i_m0_addr(m0_addr), .i_m0_data(m0_data),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we),
        .i_m1_addr(m1_addr), .i_m1_data(m1_data),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err),
        .o_m_data(m_data),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
        .o_s_addr(s_addr), .o_s_data(s_data),
        .i_s_data(s_rdata), .i_s_ack(s_ack),
        .o_grant(grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // ---------------- reset state
        #1;
        chk("rst_grant", {30'd0, grant}, 32'h0);
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'h0);
        chk("rst_acks", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
        tick(); tick();
        reset = 1'b0;

        // ---------------- single fetch
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100;
        #1;
        chk("fetch_grant_lat", {30'd0, grant}, 32'h0);
        chk("fetch_no_cyc_yet", {31'd0, s_cyc}, 32'h0);
        tick(); #1;
        chk("fetch_grant", {30'd0, grant}, 32'h1);
        chk("fetch_s_cyc", {30'd0, s_cyc, s_stb}, 32'h3);
        chk("fetch_addr", s_addr, 32'h100);
        chk("fetch_no_ack", {31'd0, m0_ack}, 32'h0);
        tick(); #1;
        tick();
        s_ack = 1; s_rdata = 32'hDEADBEEF;
        #1;
        chk("fetch_ack", {30'd0, m0_ack, m1_ack}, 32'h2);
        chk("fetch_rdata", m_data, 32'hDEADBEEF);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("fetch_ack_once", {31'd0, m0_ack}, 32'h0);
        chk("fetch_release_cyc", {31'd0, s_cyc}, 32'h0);
        tick(); #1;
        chk("fetch_idle_grant", {30'd0, grant}, 32'h0);

        // ---------------- tie after reset: m0 first
        reset = 1; #1; reset = 0;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h200;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h300;
        tick();
        s_ack = 1;
        #1;
        chk("tie1_grant_m0", {30'd0, grant}, 32'h1);
        chk("tie1_addr_m0", s_addr, 32'h200);
        chk("tie1_ack_route", {30'd0, m0_ack, m1_ack}, 32'h2);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("tie1_hold", {30'd0, grant}, 32'h1);
        tick(); #1;
        chk("tie1_idle_gap", {30'd0, grant}, 32'h0);
        chk("tie1_idle_cyc", {31'd0, s_cyc}, 32'h0);
        tick(); #1;
        chk("tie1_grant_m1", {30'd0, grant}, 32'h2);
        chk("tie1_addr_m1", s_addr, 32'h300);
        tick();
        m1_cyc = 0; m1_stb = 0;
        tick();

        // ---------------- bus lock: m1 owns, 3 beats, m0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h400; m1_data = 32'h11;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h500;
        #1;
        chk("lock_grant_m1", {30'd0, grant}, 32'h2);
        chk("lock_wdata", s_data, 32'h11);
        for (int b = 0; b < 3; b++) begin
            tick();
            s_ack = 1;
            #1;
            chk("lock_beat_ack", {30'd0, m0_ack, m1_ack}, 32'h1);
            chk("lock_beat_addr", s_addr, 32'h400);
        end
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #1;
        chk("lock_still_m1", {30'd0, grant}, 32'h2);
        tick(); #1;
        chk("lock_idle", {30'd0, grant}, 32'h0);
        tick(); #1;
        chk("lock_then_m0", {30'd0, grant}, 32'h1);
        chk("lock_m0_addr", s_addr, 32'h500);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();

        // ---------------- repeated tie: m0 was last, so m1 first
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick(); #1;
        chk("tie2_grant_m1", {30'd0, grant}, 32'h2);
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // ---------------- timeout: m1 write never acked
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h600;
        tick(); #1;
        chk("to_owned1", {31'd0, s_cyc}, 32'h1);
        for (int c = 2; c <= 8; c++) begin
            tick();
        end
        #1;
        chk("to_owned8_cyc", {31'd0, s_cyc}, 32'h1);
        chk("to_owned8_noerr", {31'd0, m1_err}, 32'h0);
        tick();
        s_ack = 1;
        #1;
        chk("to_cyc_drop9", {30'd0, s_cyc, s_stb}, 32'h0);
        chk("to_err", {31'd0, m1_err}, 32'h1);
        chk("to_late_ack_dropped", {30'd0, m0_ack, m1_ack}, 32'h0);
        tick();
        s_ack = 0;
        #1;
        chk("to_err_level", {31'd0, m1_err}, 32'h1);
        tick();
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #1;
        chk("to_err_clear", {31'd0, m1_err}, 32'h0);
        tick(); #1;
        chk("to_idle", {30'd0, grant}, 32'h0);

        // ---------------- ack exactly on the 8th owned cycle wins
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h700;
        tick();
        for (int c = 2; c <= 8; c++) begin
            tick();
        end
        s_ack = 1;
        #1;
        chk("race_ack", {31'd0, m0_ack}, 32'h1);
        chk("race_noerr", {31'd0, m0_err}, 32'h0);
        tick();
        s_ack = 0;
        #1;
        chk("race_still_owned", {31'd0, s_cyc}, 32'h1);
        chk("race_noerr_after", {31'd0, m0_err}, 32'h0);
        m0_cyc = 0; m0_stb = 0;
        tick(); tick();

        // ---------------- reset in the middle of OWN0
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h800;
        tick();
        s_ack = 1;
        #1;
        chk("rmid_pre_ack", {31'd0, m0_ack}, 32'h1);
        reset = 1;
        #1;
        chk("rmid_s_cyc", {30'd0, s_cyc, s_stb}, 32'h0);
        chk("rmid_grant", {30'd0, grant}, 32'h0);
        chk("rmid_ack", {31'd0, m0_ack}, 32'h0);
        chk("rmid_addr", s_addr, 32'h0);
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        reset = 0;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h900;
        tick(); #1;
        chk("rmid_m1_grant", {30'd0, grant}, 32'h2);
        chk("rmid_m1_addr", s_addr, 32'h900);
        m1_cyc = 0; m1_stb = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
Two-master, one-slave Wishbone (classic) arbiter. It shares the single memory port between the CPU instruction fetch unit (master 0) and the load/store unit (master 1). Grants are round-robin, a grant is held for the whole bus cycle (CYC), and a watchdog aborts any transaction the slave never acknowledges, so the CPU cannot hang on a missing ACK.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, maximum cycles a granted transaction may wait for ACK before it is aborted (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 (fetch) request signals
i_m0_addr  in  AW  master 0 address
i_m0_data  in  DW  master 0 write data
o_m0_ack, o_m0_err  out  1 each  master 0 completion / abort
i_m1_cyc, i_m1_stb, i_m1_we  in  1 each  master 1 (load/store) request signals
i_m1_addr  in  AW  master 1 address
i_m1_data  in  DW  master 1 write data
o_m1_ack, o_m1_err  out  1 each  master 1 completion / abort
o_m_data  out  DW  slave read data, broadcast to both masters
o_s_cyc, o_s_stb, o_s_we  out  1 each  to slave
o_s_addr  out  AW  to slave
o_s_data  out  DW  write data to slave
i_s_data  in  DW  read data from slave
i_s_ack  in  1  slave acknowledge
o_grant  out  2  one-hot owner (01 = m0, 10 = m1, 00 = none)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, port named reset. While reset is high and on release: state IDLE, o_grant = 00, all o_s_* = 0, all acks/errs = 0, timeout counter = 0, last_owner = m1 (so m0 wins the first tie).
- States: IDLE, OWN0, OWN1, ABORT0, ABORT1.
- IDLE:
  - only i_m0_cyc high -> OWN0; only i_m1_cyc high -> OWN1.
  - both high -> grant the master that is not last_owner.
  - o_grant is registered and updates on the same edge as the state.
- Request latency: the earliest slave CYC/STB is the cycle after the request is sampled (1-cycle grant latency).
- OWNn:
  - o_s_cyc/stb/we/addr/data are combinationally muxed from master n.
  - i_s_ack is routed only to o_mn_ack, combinationally in the same cycle; the other master's ack/err stay 0.
  - o_m_data = i_s_data at all times.
  - Leave when i_mn_cyc = 0: go to IDLE, set last_owner = n, o_grant = 00.
  - IDLE always lasts at least one cycle between owners (no direct handoff).
- Bus lock: the non-owner's CYC/STB are ignored while another master owns the bus, including multiple STB beats inside one CYC.
- Watchdog:
  - the counter is cleared on entry to OWNn and on every i_s_ack; it increments each cycle in OWNn while ack is low.
  - When it reaches TIMEOUT with no ack in that cycle -> ABORTn.
- ABORTn:
  - o_s_cyc = o_s_stb = 0; o_mn_err = 1 (level) for as long as i_mn_cyc stays high.
  - When i_mn_cyc drops -> IDLE, last_owner = n.
  - An i_s_ack arriving in ABORTn is dropped and never forwarded.
- Simultaneous events:
  - ack on the same cycle the counter hits TIMEOUT: the ack wins, no abort.
  - master drops CYC on the same cycle ack arrives: the ack is forwarded, then go to IDLE.
- Owner drops CYC mid-transaction without ack: the cycle is released (legal Wishbone abort), no err.
- Reset asserted mid-transaction: immediate return to reset values; the slave sees CYC fall asynchronously.
- o_s_* outputs are 0 (not don't-care) in IDLE and ABORTn.

Test Plan:
- Single fetch: m0 cyc/stb, addr 0x100; slave acks 2 cycles after STB with data 0xDEADBEEF -> o_grant = 01 one cycle after the request; o_m0_ack pulses once with o_m_data = 0xDEADBEEF; o_m1_ack stays 0.
- Tie: m0 and m1 request together after reset -> m0 served first; m1 granted after exactly one IDLE cycle once m0 drops CYC. Repeat the tie -> m1 first (round-robin).
- Lock: m1 owns the bus and issues 3 STB beats in one CYC while m0 requests -> all 3 acks go to m1; m0 granted only after m1's CYC falls.
- Timeout: TIMEOUT = 8, slave never acks m1's write -> o_s_cyc drops on the 9th owned cycle; o_m1_err stays high until m1 drops CYC; a late ack injected in ABORT1 does not reach o_m1_ack.
- Ack/timeout race: ack arrives exactly on count 8 (TIMEOUT = 8) -> o_m0_ack = 1, o_m0_err never asserted.
- Reset mid-transaction: assert reset while in OWN0 with STB high -> all outputs 0 immediately, asynchronously; after release, m1-only request is granted normally.
